// File: rtl/udma_uart_pkg.sv
// Shared constants and types for the uDMA UART RX polling engine.
package udma_uart_pkg;

  localparam logic [4:0] REG_ADDR_VALID = 5'h0C;
  localparam logic [4:0] REG_ADDR_DATA  = 5'h0D;
  localparam logic [4:0] REG_ADDR_ERROR = 5'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RD_VALID,
    ST_RD_DATA,
    ST_RD_ERR,
    ST_PUSH
  } poll_state_e;

endpackage

// File: rtl/udma_uart_cfg_arb.sv
// Combinational 2:1 cfg bus mux; the host always wins, the engine gets the leftovers.
module udma_uart_cfg_arb (
  input  logic [31:0] host_cfg_data_i,
  input  logic [4:0]  host_cfg_addr_i,
  input  logic        host_cfg_valid_i,
  input  logic        host_cfg_rwn_i,
  output logic [31:0] host_cfg_data_o,
  output logic        host_cfg_ready_o,
  input  logic        eng_req,
  input  logic [4:0]  eng_addr,
  output logic        eng_grant,
  output logic [31:0] uart_cfg_data_o,
  output logic [4:0]  uart_cfg_addr_o,
  output logic        uart_cfg_valid_o,
  output logic        uart_cfg_rwn_o,
  input  logic [31:0] uart_cfg_data_i,
  input  logic        uart_cfg_ready_i
);

  always_comb begin
    if (host_cfg_valid_i) begin
      uart_cfg_data_o  = host_cfg_data_i;
      uart_cfg_addr_o  = host_cfg_addr_i;
      uart_cfg_valid_o = 1'b1;
      uart_cfg_rwn_o   = host_cfg_rwn_i;
      host_cfg_data_o  = uart_cfg_data_i;
      host_cfg_ready_o = uart_cfg_ready_i;
    end else begin
      uart_cfg_data_o  = '0;
      uart_cfg_addr_o  = eng_addr;
      uart_cfg_valid_o = eng_req;
      uart_cfg_rwn_o   = 1'b1;
      host_cfg_data_o  = '0;
      host_cfg_ready_o = 1'b0;
    end
  end

  // Engine read data is only meaningful on the cycle it actually owns the bus.
  assign eng_grant = eng_req & ~host_cfg_valid_i & uart_cfg_ready_i;

endmodule

// File: rtl/udma_uart_poll_ctrl.sv
// UART RX polling engine: polls VALID, fetches DATA (and ERROR), streams the byte out.
module udma_uart_poll_ctrl
  import udma_uart_pkg::*;
#(
  parameter int unsigned INTERVAL_W = 16,
  parameter logic [4:0]  ADDR_VALID = REG_ADDR_VALID,
  parameter logic [4:0]  ADDR_DATA  = REG_ADDR_DATA,
  parameter logic [4:0]  ADDR_ERROR = REG_ADDR_ERROR
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [31:0]           host_cfg_data_i,
  input  logic [4:0]            host_cfg_addr_i,
  input  logic                  host_cfg_valid_i,
  input  logic                  host_cfg_rwn_i,
  output logic [31:0]           host_cfg_data_o,
  output logic                  host_cfg_ready_o,
  output logic [31:0]           uart_cfg_data_o,
  output logic [4:0]            uart_cfg_addr_o,
  output logic                  uart_cfg_valid_o,
  output logic                  uart_cfg_rwn_o,
  input  logic [31:0]           uart_cfg_data_i,
  input  logic                  uart_cfg_ready_i,
  input  logic                  poll_en_i,
  input  logic [INTERVAL_W-1:0] poll_interval_i,
  input  logic                  err_chk_en_i,
  output logic [7:0]            rx_data_o,
  output logic [1:0]            rx_err_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  busy_o
);

  poll_state_e           state;
  logic [INTERVAL_W-1:0] cnt;
  logic                  eng_req;
  logic                  eng_grant;
  logic [4:0]            eng_addr;

  always_comb begin
    eng_req  = 1'b0;
    eng_addr = ADDR_VALID;
    case (state)
      ST_RD_VALID: eng_req = 1'b1;
      ST_RD_DATA:  begin eng_req = 1'b1; eng_addr = ADDR_DATA;  end
      ST_RD_ERR:   begin eng_req = 1'b1; eng_addr = ADDR_ERROR; end
      default:     ;
    endcase
  end

  udma_uart_cfg_arb u_arb (
    .host_cfg_data_i  (host_cfg_data_i),
    .host_cfg_addr_i  (host_cfg_addr_i),
    .host_cfg_valid_i (host_cfg_valid_i),
    .host_cfg_rwn_i   (host_cfg_rwn_i),
    .host_cfg_data_o  (host_cfg_data_o),
    .host_cfg_ready_o (host_cfg_ready_o),
    .eng_req          (eng_req),
    .eng_addr         (eng_addr),
    .eng_grant        (eng_grant),
    .uart_cfg_data_o  (uart_cfg_data_o),
    .uart_cfg_addr_o  (uart_cfg_addr_o),
    .uart_cfg_valid_o (uart_cfg_valid_o),
    .uart_cfg_rwn_o   (uart_cfg_rwn_o),
    .uart_cfg_data_i  (uart_cfg_data_i),
    .uart_cfg_ready_i (uart_cfg_ready_i)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      rx_valid_o <= 1'b0;
      rx_data_o  <= '0;
      rx_err_o   <= '0;
      busy_o     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (poll_en_i) begin
          cnt    <= poll_interval_i;
          state  <= ST_WAIT;
          busy_o <= 1'b1;
        end
        ST_WAIT: begin
          if (!poll_en_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else if (cnt == '0) state <= ST_RD_VALID;
          else cnt <= cnt - {{(INTERVAL_W-1){1'b0}}, 1'b1};
        end
        ST_RD_VALID: begin
          if (eng_grant) begin
            if (uart_cfg_data_i[0]) state <= ST_RD_DATA;
            else begin
              cnt   <= poll_interval_i;
              state <= ST_WAIT;
            end
          end else if (!poll_en_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
        end
        // From here on the byte has left the reg if, so poll_en_i no longer aborts.
        ST_RD_DATA: if (eng_grant) begin
          rx_data_o <= uart_cfg_data_i[7:0];
          if (err_chk_en_i) state <= ST_RD_ERR;
          else begin
            rx_err_o   <= '0;
            rx_valid_o <= 1'b1;
            state      <= ST_PUSH;
          end
        end
        ST_RD_ERR: if (eng_grant) begin
          rx_err_o   <= uart_cfg_data_i[1:0];
          rx_valid_o <= 1'b1;
          state      <= ST_PUSH;
        end
        ST_PUSH: if (rx_ready_i) begin
          rx_valid_o <= 1'b0;
          cnt        <= poll_interval_i;
          if (poll_en_i) state <= ST_WAIT;
          else begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          rx_valid_o <= 1'b0;
          busy_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udma_uart_poll_ctrl.sv
// Bench for udma_uart_poll_ctrl: reg-if model, arbitration vector table, directed corners, random scoreboard.
module tb_udma_uart_poll_ctrl;

  localparam logic [4:0] A_VALID = 5'h0C;
  localparam logic [4:0] A_DATA  = 5'h0D;
  localparam logic [4:0] A_ERR   = 5'h0A;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [31:0] host_cfg_data_i;
  logic [4:0]  host_cfg_addr_i;
  logic        host_cfg_valid_i;
  logic        host_cfg_rwn_i;
  logic [31:0] host_cfg_data_o;
  logic        host_cfg_ready_o;
  logic [31:0] uart_cfg_data_o;
  logic [4:0]  uart_cfg_addr_o;
  logic        uart_cfg_valid_o;
  logic        uart_cfg_rwn_o;
  logic [31:0] uart_cfg_data_i;
  logic        uart_cfg_ready_i;
  logic        poll_en_i;
  logic [15:0] poll_interval_i;
  logic        err_chk_en_i;
  logic [7:0]  rx_data_o;
  logic [1:0]  rx_err_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  udma_uart_poll_ctrl dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .host_cfg_data_i(host_cfg_data_i), .host_cfg_addr_i(host_cfg_addr_i),
    .host_cfg_valid_i(host_cfg_valid_i), .host_cfg_rwn_i(host_cfg_rwn_i),
    .host_cfg_data_o(host_cfg_data_o), .host_cfg_ready_o(host_cfg_ready_o),
    .uart_cfg_data_o(uart_cfg_data_o), .uart_cfg_addr_o(uart_cfg_addr_o),
    .uart_cfg_valid_o(uart_cfg_valid_o), .uart_cfg_rwn_o(uart_cfg_rwn_o),
    .uart_cfg_data_i(uart_cfg_data_i), .uart_cfg_ready_i(uart_cfg_ready_i),
    .poll_en_i(poll_en_i), .poll_interval_i(poll_interval_i), .err_chk_en_i(err_chk_en_i),
    .rx_data_o(rx_data_o), .rx_err_o(rx_err_o), .rx_valid_o(rx_valid_o),
    .rx_ready_i(rx_ready_i), .busy_o(busy_o)
  );

  // UART register interface model: VALID flag, DATA byte, ERROR bits, read-to-clear.
  logic        rf_flag = 1'b0;
  logic [7:0]  rf_data = 8'h00;
  logic [1:0]  rf_err  = 2'b00;
  logic        clr_flag_p = 1'b0, clr_err_p = 1'b0;
  int          ld_cnt = 0, ld_done = 0;
  logic [7:0]  ld_data;
  logic [1:0]  ld_err;
  logic        ovr_en;
  logic [31:0] ovr_data;
  logic        uart_rdy;
  logic [31:0] rf_rdata;
  logic        bus_rd, eng_done;
  int          cyc = 0;
  logic [4:0]  acc_q[$];
  int          acc_cyc[$];

  always_comb begin
    rf_rdata = 32'h0;
    case (uart_cfg_addr_o)
      A_VALID: rf_rdata = {31'h0, rf_flag};
      A_DATA:  rf_rdata = {24'h0, rf_data};
      A_ERR:   rf_rdata = {30'h0, rf_err};
      default: rf_rdata = 32'h0;
    endcase
  end
  assign uart_cfg_data_i  = ovr_en ? ovr_data : rf_rdata;
  assign uart_cfg_ready_i = uart_rdy;
  assign bus_rd   = uart_cfg_valid_o && uart_cfg_rwn_o && uart_rdy;
  assign eng_done = bus_rd && !host_cfg_valid_i;

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (clr_flag_p) rf_flag <= 1'b0;
    if (clr_err_p)  rf_err  <= 2'b00;
    if (ld_cnt != ld_done) begin
      rf_flag <= 1'b1;
      rf_data <= ld_data;
      rf_err  <= ld_err;
      ld_done <= ld_cnt;
    end
  end

  always @(negedge clk_i) begin
    clr_flag_p <= bus_rd && uart_cfg_addr_o == A_DATA;
    clr_err_p  <= bus_rd && uart_cfg_addr_o == A_ERR;
    if (eng_done) begin
      acc_q.push_back(uart_cfg_addr_o);
      acc_cyc.push_back(cyc);
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load(input logic [7:0] d, input logic [1:0] e);
    ld_data = d;
    ld_err  = e;
    ld_cnt++;
  endtask

  task automatic wait_rx(input string nm);
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk_i);
      if (rx_valid_o) ok = 1;
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  // Returns at the negedge of an engine VALID read that will see the flag set.
  task automatic wait_valid_hit(input string nm);
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk_i);
      if (eng_done && uart_cfg_addr_o == A_VALID && rf_flag) ok = 1;
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic handshake();
    tick();
    rx_ready_i = 1'b1;
    @(negedge clk_i);
    tick();
    rx_ready_i = 1'b0;
  endtask

  typedef struct {
    logic hv; logic [4:0] ha; logic hr; logic [31:0] hd; logic ur; logic [31:0] ud;
    logic ev; logic [4:0] ea; logic er; logic [31:0] eud; logic ehr; logic [31:0] ehd;
  } vec_t;
  vec_t tbl[6];

  typedef struct { logic [7:0] d; logic [1:0] e; } byte_t;
  byte_t exp_q[$];

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, h, hp, delivered;
    bit prev_hold;
    logic [7:0] prev_d;
    logic [1:0] prev_e;
    byte_t b;

    rstn_i = 1'b0; host_cfg_data_i = '0; host_cfg_addr_i = '0; host_cfg_valid_i = 1'b0;
    host_cfg_rwn_i = 1'b1; poll_en_i = 1'b0; poll_interval_i = '0; err_chk_en_i = 1'b0;
    rx_ready_i = 1'b0; uart_rdy = 1'b1; ovr_en = 1'b0; ovr_data = '0; ld_data = '0; ld_err = '0;

    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_rx_valid", 32'(rx_valid_o), 32'd0);
    chk("rst_rx_data", 32'(rx_data_o), 32'd0);
    chk("rst_rx_err", 32'(rx_err_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_no_req", 32'(uart_cfg_valid_o), 32'd0);
    tick();
    rstn_i = 1'b1;
    tick();

    // Arbitration vector table, engine idle
    tbl[0] = '{1'b1, 5'h0A, 1'b1, 32'hDEADBEEF, 1'b1, 32'h00001234, 1'b1, 5'h0A, 1'b1, 32'hDEADBEEF, 1'b1, 32'h00001234};
    tbl[1] = '{1'b1, 5'h03, 1'b0, 32'hCAFEF00D, 1'b0, 32'h00000055, 1'b1, 5'h03, 1'b0, 32'hCAFEF00D, 1'b0, 32'h00000055};
    tbl[2] = '{1'b0, 5'h1F, 1'b0, 32'hFFFFFFFF, 1'b1, 32'h0000FFFF, 1'b0, 5'h00, 1'b1, 32'h0,        1'b0, 32'h0};
    tbl[3] = '{1'b1, 5'h0D, 1'b1, 32'h00000000, 1'b1, 32'h000000A5, 1'b1, 5'h0D, 1'b1, 32'h0,        1'b1, 32'h000000A5};
    tbl[4] = '{1'b0, 5'h0C, 1'b1, 32'h12345678, 1'b0, 32'h00000077, 1'b0, 5'h00, 1'b1, 32'h0,        1'b0, 32'h0};
    tbl[5] = '{1'b1, 5'h1F, 1'b0, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b1, 5'h1F, 1'b0, 32'h00000001, 1'b1, 32'hFFFFFFFF};
    ovr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      host_cfg_valid_i = tbl[i].hv; host_cfg_addr_i = tbl[i].ha; host_cfg_rwn_i = tbl[i].hr;
      host_cfg_data_i = tbl[i].hd; uart_rdy = tbl[i].ur; ovr_data = tbl[i].ud;
      #1;
      chk($sformatf("tbl%0d_uvalid", i), 32'(uart_cfg_valid_o), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_urwn", i), 32'(uart_cfg_rwn_o), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_udata", i), uart_cfg_data_o, tbl[i].eud);
      chk($sformatf("tbl%0d_hdata", i), host_cfg_data_o, tbl[i].ehd);
      if (tbl[i].hv) begin
        chk($sformatf("tbl%0d_uaddr", i), 32'(uart_cfg_addr_o), 32'(tbl[i].ea));
        chk($sformatf("tbl%0d_hready", i), 32'(host_cfg_ready_o), 32'(tbl[i].ehr));
      end
      tick();
    end
    host_cfg_valid_i = 1'b0; host_cfg_rwn_i = 1'b1; host_cfg_data_i = '0;
    ovr_en = 1'b0; uart_rdy = 1'b1;
    tick();

    // Basic poll, interval 3, no error check; loaded error bits must not leak out
    poll_interval_i = 16'd3;
    load(8'hA5, 2'b11);
    poll_en_i = 1'b1;
    wait_rx("basic_rx_timeout");
    chk("basic_data", 32'(rx_data_o), 32'hA5);
    chk("basic_err", 32'(rx_err_o), 32'd0);
    chk("basic_busy", 32'(busy_o), 32'd1);
    chk("basic_order", {19'h0, acc_q[acc_q.size()-2], 3'h0, acc_q[acc_q.size()-1]}, {19'h0, A_VALID, 3'h0, A_DATA});
    chk("basic_latency", 32'(cyc - acc_cyc[acc_q.size()-2]), 32'd2);
    tick();
    rx_ready_i = 1'b1;
    @(negedge clk_i);
    h = cyc;
    n0 = acc_q.size();
    tick();
    rx_ready_i = 1'b0;
    @(negedge clk_i);
    chk("basic_rx_drop", 32'(rx_valid_o), 32'd0);
    for (int i = 0; i < 20 && acc_q.size() == n0; i++) @(negedge clk_i);
    chk("basic_next_poll_addr", 32'(acc_q[acc_q.size()-1]), 32'(A_VALID));
    chk("basic_next_poll_gap", 32'(acc_cyc[acc_q.size()-1] - h), 32'd5);

    // Error capture, then backpressure on that pending byte
    tick();
    err_chk_en_i = 1'b1;
    load(8'h3C, 2'b10);
    wait_rx("err_rx_timeout");
    chk("err_data", 32'(rx_data_o), 32'h3C);
    chk("err_err", 32'(rx_err_o), 32'd2);
    chk("err_order", {17'h0, acc_q[acc_q.size()-3], acc_q[acc_q.size()-2], acc_q[acc_q.size()-1]},
        {17'h0, A_VALID, A_DATA, A_ERR});
    chk("err_latency", 32'(cyc - acc_cyc[acc_q.size()-3]), 32'd3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("bp_valid", 32'(rx_valid_o), 32'd1);
      chk("bp_data", {22'h0, rx_err_o, rx_data_o}, {22'h0, 2'b10, 8'h3C});
      chk("bp_no_req", 32'(uart_cfg_valid_o), 32'd0);
    end
    handshake();
    @(negedge clk_i);
    chk("bp_rx_drop", 32'(rx_valid_o), 32'd0);
    chk("bp_busy_wait", 32'(busy_o), 32'd1);

    // Host priority during RD_DATA
    err_chk_en_i = 1'b0;
    tick();
    load(8'h5A, 2'b00);
    wait_valid_hit("hp_valid_timeout");
    tick();
    hp = acc_q.size();
    host_cfg_valid_i = 1'b1; host_cfg_addr_i = A_VALID; host_cfg_rwn_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("hp_host_ready", 32'(host_cfg_ready_o), 32'd1);
      chk("hp_host_data", host_cfg_data_o, 32'd1);
      tick();
    end
    host_cfg_valid_i = 1'b0;
    chk("hp_no_eng_access", 32'(acc_q.size()), 32'(hp));
    @(negedge clk_i);
    chk("hp_eng_data_first", {26'h0, eng_done, uart_cfg_addr_o}, {26'h0, 1'b1, A_DATA});
    wait_rx("hp_rx_timeout");
    chk("hp_data", 32'(rx_data_o), 32'h5A);
    handshake();

    // Disable while the DATA read is stalled
    load(8'h96, 2'b01);
    wait_valid_hit("dis_valid_timeout");
    tick();
    uart_rdy = 1'b0;
    tick();
    poll_en_i = 1'b0;
    tick();
    uart_rdy = 1'b1;
    wait_rx("dis_rx_timeout");
    chk("dis_data", 32'(rx_data_o), 32'h96);
    handshake();
    @(negedge clk_i);
    chk("dis_busy", 32'(busy_o), 32'd0);
    chk("dis_rx_valid", 32'(rx_valid_o), 32'd0);

    // Disable in WAIT
    tick();
    poll_interval_i = 16'd20;
    poll_en_i = 1'b1;
    tick();
    poll_en_i = 1'b0;
    @(negedge clk_i);
    chk("wdis_busy_wait", 32'(busy_o), 32'd1);
    @(negedge clk_i);
    chk("wdis_busy_idle", 32'(busy_o), 32'd0);
    n0 = acc_q.size();
    repeat (25) @(negedge clk_i);
    chk("wdis_no_reads", 32'(acc_q.size()), 32'(n0));

    // Reset during PUSH
    tick();
    poll_interval_i = 16'd1;
    load(8'h11, 2'b00);
    poll_en_i = 1'b1;
    wait_rx("rst_push_rx_timeout");
    #2 rstn_i = 1'b0;
    #1;
    chk("rstp_rx_valid", 32'(rx_valid_o), 32'd0);
    chk("rstp_busy", 32'(busy_o), 32'd0);
    chk("rstp_data", 32'(rx_data_o), 32'd0);
    tick();
    rstn_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("rstp_restart_busy", 32'(busy_o), 32'd1);
    chk("rstp_restart_wait", 32'(uart_cfg_valid_o), 32'd0);
    n0 = acc_q.size();
    for (int i = 0; i < 10 && acc_q.size() == n0; i++) @(negedge clk_i);
    chk("rstp_polls_again", 32'(acc_q.size() > n0), 32'd1);

    // Random traffic against a byte-stream scoreboard
    for (int ph = 0; ph < 2; ph++) begin
      tick();
      err_chk_en_i = ph[0];
      poll_en_i = 1'b1;
      prev_hold = 0;
      delivered = 0;
      for (int c = 0; c < 1300; c++) begin
        @(negedge clk_i);
        if (host_cfg_valid_i) begin
          chk("rnd_host_ready", 32'(host_cfg_ready_o), 32'(uart_rdy));
          chk("rnd_host_data", host_cfg_data_o, {31'h0, rf_flag});
        end
        if (rx_valid_o && !host_cfg_valid_i) chk("rnd_push_no_req", 32'(uart_cfg_valid_o), 32'd0);
        if (prev_hold) chk("rnd_hold", {21'h0, rx_valid_o, rx_err_o, rx_data_o}, {21'h0, 1'b1, prev_e, prev_d});
        if (rx_valid_o && rx_ready_i) begin
          if (exp_q.size() == 0) chk("rnd_spurious_byte", 32'd1, 32'd0);
          else begin
            b = exp_q.pop_front();
            chk("rnd_byte", {22'h0, rx_err_o, rx_data_o}, {22'h0, b.e, b.d});
            delivered++;
          end
        end
        prev_hold = rx_valid_o && !rx_ready_i;
        prev_d = rx_data_o;
        prev_e = rx_err_o;
        tick();
        uart_rdy         = ($urandom_range(0, 3) != 0);
        host_cfg_valid_i = ($urandom_range(0, 7) == 0);
        host_cfg_addr_i  = A_VALID;
        host_cfg_rwn_i   = 1'b1;
        rx_ready_i       = ($urandom_range(0, 2) != 0);
        poll_interval_i  = 16'($urandom_range(0, 3));
        if (c < 1100 && exp_q.size() == 0 && !rf_flag && ld_cnt == ld_done && $urandom_range(0, 2) == 0) begin
          b.d = 8'($urandom);
          b.e = 2'($urandom);
          load(b.d, b.e);
          if (!ph[0]) b.e = 2'b00;
          exp_q.push_back(b);
        end
      end
      chk("rnd_drained", 32'(exp_q.size()), 32'd0);
      chk("rnd_activity", 32'(delivered >= 10), 32'd1);
      host_cfg_valid_i = 1'b0;
      rx_ready_i = 1'b0;
      uart_rdy = 1'b1;
      poll_en_i = 1'b0;
      repeat (5) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/udma_uart_poll_ctrl.md
Name: udma_uart_poll_ctrl

Overview:
- Hardware polling engine for the uDMA UART register interface. With polling enabled, it repeatedly reads the RX VALID register; when a byte is present it reads DATA (clearing VALID) and optionally ERROR, then presents the byte on a valid/ready stream.
- Sits between the host config port and the UART register interface and shares the 5-bit cfg bus between host and engine. The host always has priority.

Parameters:
- INTERVAL_W, 16, width of poll interval counter (cycles between VALID polls).
- ADDR_VALID, 5'h0C, cfg word address of the RX VALID register.
- ADDR_DATA, 5'h0D, cfg word address of the RX DATA register.
- ADDR_ERROR, 5'h0A, cfg word address of the ERROR register.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- host_cfg_data_i  in  32  host write data
- host_cfg_addr_i  in  5  host word address
- host_cfg_valid_i  in  1  host access request
- host_cfg_rwn_i  in  1  host read(1)/write(0)
- host_cfg_data_o  out  32  host read data
- host_cfg_ready_o  out  1  host access accepted
- uart_cfg_data_o  out  32  to reg if: write data
- uart_cfg_addr_o  out  5  to reg if: address
- uart_cfg_valid_o  out  1  to reg if: access valid
- uart_cfg_rwn_o  out  1  to reg if: read/write
- uart_cfg_data_i  in  32  from reg if: combinational read data
- uart_cfg_ready_i  in  1  from reg if: access accepted
- poll_en_i  in  1  enable polling engine
- poll_interval_i  in  INTERVAL_W  idle cycles between VALID polls
- err_chk_en_i  in  1  read ERROR after each byte
- rx_data_o  out  8  received byte
- rx_err_o  out  2  {parity, overflow} captured for this byte
- rx_valid_o  out  1  byte available
- rx_ready_i  in  1  consumer accepts byte
- busy_o  out  1  engine not in IDLE

Behaviour:
- Reset: state IDLE, counter 0, rx_valid_o=0, rx_data_o=0, rx_err_o=0, busy_o=0.
- Arbitration (combinational):
  - host_cfg_valid_i=1: host signals pass straight through to the uart_cfg_* outputs. host_cfg_ready_o=uart_cfg_ready_i and host_cfg_data_o=uart_cfg_data_i.
  - Otherwise the engine request drives the bus with rwn=1 and data_o=0. host_cfg_data_o=0.
- Engine access completes in the cycle where the engine requests, host_cfg_valid_i=0 and uart_cfg_ready_i=1. Read data is sampled at that clock edge. If not completed, the engine holds its request with the same address.
- A host read of DATA or ERROR clears the flags in the reg if. The engine does not detect this; it simply sees VALID=0 on its next poll.
- States:
  - IDLE: engine requests nothing. poll_en_i=1 -> load counter with poll_interval_i, go to WAIT.
  - WAIT: counter≠0 decrements each cycle. Counter=0 -> RD_VALID; interval 0 therefore gives one WAIT cycle. poll_en_i=0 -> IDLE.
  - RD_VALID: request a read of ADDR_VALID. On completion, bit0=1 -> RD_DATA; bit0=0 -> reload counter, go to WAIT. If poll_en_i=0 and the access has not completed -> IDLE.
  - RD_DATA: request a read of ADDR_DATA. On completion capture rx_data_o=data[7:0]. Then go to RD_ERR if err_chk_en_i=1, else clear rx_err_o and go to PUSH.
  - RD_ERR: request a read of ADDR_ERROR. On completion capture rx_err_o=data[1:0], go to PUSH.
  - PUSH: rx_valid_o=1. When rx_ready_i=1, next cycle rx_valid_o=0, reload counter, go to WAIT (or IDLE if poll_en_i=0).
- poll_en_i deasserted in RD_DATA, RD_ERR or PUSH: the sequence completes and the byte is delivered. A byte already read from DATA is never dropped.
- rx_data_o and rx_err_o are stable while rx_valid_o=1. They change only on capture.
- Minimum latency with no host traffic and interval 0: VALID=1 detected to rx_valid_o=1 is 2 cycles without error check, 3 with.
- Mid-operation reset returns to the reset state immediately.
- busy_o=1 in every state except IDLE.

Decomposition:
- Package udma_uart_pkg:
  - register address constants (VALID, DATA, ERROR);
  - poll state enum typedef.
- One sub-module, udma_uart_cfg_arb: the combinational 2:1 cfg mux with host priority, plus the engine-grant signal.
- The FSM and interval counter live in the top.

Test Plan:
- Basic poll: poll_en=1, interval=3, err_chk=0; reg if holds VALID=1, DATA=0xA5 -> VALID read, DATA read, rx_valid_o=1 with rx_data_o=0xA5 and rx_err_o=0; ready=1 -> engine returns to WAIT and next VALID poll follows 4 cycles later.
- Error capture: err_chk=1, DATA=0x3C, ERROR=2'b10 -> three reads in order VALID, DATA, ERROR; rx_data_o=0x3C and rx_err_o=2'b10.
- Host priority: host_cfg_valid_i held for 5 cycles during RD_DATA -> host sees ready each cycle with correct read data; engine read of 0x0D completes only in the first cycle after host_cfg_valid_i drops.
- Backpressure: rx_ready_i=0 for 10 cycles with a byte pending -> rx_valid_o stays 1, data stable, no cfg requests issued; ready=1 -> handshake completes, then WAIT.
- Disable mid-sequence: poll_en_i dropped the cycle after the DATA read starts -> byte still delivered, then IDLE with busy_o=0. Disable in WAIT -> IDLE next cycle with no further reads.
- Reset during PUSH: assert rstn_i=0 -> rx_valid_o=0, busy_o=0 immediately. After release with poll_en=1, engine restarts from WAIT.
